// File: rtl/mem_access_unit_if.sv
// Bundles the load/store request, completion response and data-memory
// signals of mem_access_unit. The unit attaches through the slave modport;
// the pipeline/memory side (or a bench) attaches through the master modport.
interface mem_access_unit_if #(
  parameter int DATA_BIT_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_wr;
  logic [1:0]                req_size;
  logic                      req_signed;
  logic [DATA_BIT_WIDTH-1:0] req_addr;
  logic [DATA_BIT_WIDTH-1:0] req_wdata;
  logic                      resp_valid;
  logic [DATA_BIT_WIDTH-1:0] resp_rdata;
  logic                      resp_err;
  logic                      mem_wr;
  logic [DATA_BIT_WIDTH-1:0] mem_addr;
  logic [DATA_BIT_WIDTH-1:0] mem_wdata;
  logic [DATA_BIT_WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a word-wide data memory.
// Handles byte/halfword/word accesses with little-endian lanes, sign or
// zero extension on loads, read-modify-write for sub-word stores, and
// flags misaligned or illegal-size requests without touching memory.
module mem_access_unit #(
  parameter int DATA_BIT_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus
);
  localparam int W = DATA_BIT_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t         state_q, state_d;
  logic           wr_q, wr_d;
  logic [1:0]     size_q, size_d;
  logic           sgn_q, sgn_d;
  logic [W-1:0]   addr_q, addr_d;
  logic [W-1:0]   wdata_q, wdata_d;
  logic           err_q, err_d;
  logic [W-1:0]   rdata_q, rdata_d;
  logic [W-1:0]   merged_q, merged_d;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'b11) || (size == 2'b01 && lo[0]) || (size == 2'b10 && lo != 2'b00);
  endfunction

  // Pick the addressed lane out of a memory word and extend it to full width.
  function automatic logic [W-1:0] load_extract(input logic [W-1:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = word[{lo[1], 4'b0000} +: 16];
    case (size)
      2'b00:   return {{(W-8){sgn & b[7]}}, b};
      2'b01:   return {{(W-16){sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  // Replace the addressed byte/halfword lane of a memory word with store data.
  function automatic logic [W-1:0] merge_lane(input logic [W-1:0] word, input logic [W-1:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lo);
    logic [W-1:0] mask;
    logic [W-1:0] ins;
    if (size == 2'b00) begin
      mask = W'(8'hFF) << {lo, 3'b000};
      ins  = W'(wdata[7:0]) << {lo, 3'b000};
    end else begin
      mask = W'(16'hFFFF) << {lo[1], 4'b0000};
      ins  = W'(wdata[15:0]) << {lo[1], 4'b0000};
    end
    return (word & ~mask) | ins;
  endfunction

  // State and captured-request registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      sgn_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      merged_q <= merged_d;
    end
  end

  // Next-state logic and state-decoded outputs. Write strobe and response
  // are gated by rst_n so a request aborted by reset commits nothing in
  // the cycle reset is asserted.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    merged_d = merged_q;

    bus.req_ready  = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;

    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          wr_d    = bus.req_wr;
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = misaligned(bus.req_size, bus.req_addr[1:0]);
          rdata_d = '0;
          state_d = err_d ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        bus.mem_addr = {addr_q[W-1:2], 2'b00};
        if (!wr_q) begin
          rdata_d = load_extract(bus.mem_rdata, size_q, addr_q[1:0], sgn_q);
          state_d = RESP;
        end else if (size_q == 2'b10) begin
          bus.mem_wr    = rst_n;
          bus.mem_wdata = rst_n ? wdata_q : '0;
          state_d       = RESP;
        end else begin
          merged_d = merge_lane(bus.mem_rdata, wdata_q, size_q, addr_q[1:0]);
          state_d  = WRITE;
        end
      end
      WRITE: begin
        bus.mem_addr  = {addr_q[W-1:2], 2'b00};
        bus.mem_wr    = rst_n;
        bus.mem_wdata = rst_n ? merged_q : '0;
        state_d       = RESP;
      end
      RESP: begin
        bus.resp_valid = rst_n;
        bus.resp_err   = err_q;
        bus.resp_rdata = rdata_q;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a word memory responder, a behavioural
// reference of load/store semantics, directed scenarios and random traffic.
module tb_mem_access_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_BIT_WIDTH(W)) bus ();

  mem_access_unit #(.DATA_BIT_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [W-1:0] mem     [256];
  logic [W-1:0] ref_mem [256];
  logic         pre_we;
  logic [7:0]   pre_idx;
  logic [W-1:0] pre_val;

  int n_cmp = 0, n_err = 0;
  int wr_cnt = 0, resp_cnt = 0, acc_cnt = 0, wdata_viol = 0;
  logic [W-1:0] last_wa, last_wd;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  // Memory responder plus event counters for writes, responses and acceptances.
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    else if (bus.mem_wr) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    if (bus.mem_wr) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= bus.mem_addr;
      last_wd <= bus.mem_wdata;
    end else if (bus.mem_wdata !== '0) begin
      wdata_viol <= wdata_viol + 1;
    end
    if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
    if (rst_n && bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [W-1:0] val);
    pre_idx = 8'(idx);
    pre_val = val;
    pre_we  = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
    ref_mem[idx] = val;
  endtask

  // Reference: what a request should return, how long it takes, and what it writes.
  function automatic void model(input bit wr, input bit [1:0] size, input bit sgn,
                                input bit [31:0] a, input bit [31:0] wd,
                                output bit err, output bit [31:0] rd, output int lat,
                                output int nwr, output bit [31:0] newword);
    bit [31:0] word, mask, v;
    int bits, sh;
    word    = ref_mem[a[9:2]];
    err     = (size == 3) || (size == 1 && a[0]) || (size == 2 && a[1:0] != 0);
    rd      = 0;
    nwr     = 0;
    newword = word;
    bits    = (size == 0) ? 8 : 16;
    sh      = (size == 0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
    mask    = ((32'd1 << bits) - 1) << sh;
    if (err) begin
      lat = 1;
    end else if (!wr) begin
      lat = 2;
      if (size == 2) rd = word;
      else begin
        v = (word & mask) >> sh;
        if (sgn && v[bits-1]) v = v | ~((32'd1 << bits) - 1);
        rd = v;
      end
    end else begin
      nwr = 1;
      if (size == 2) begin
        lat = 2;
        newword = wd;
      end else begin
        lat = 3;
        newword = (word & ~mask) | ((wd << sh) & mask);
      end
    end
  endfunction

  task automatic wait_resp(output int seen);
    seen = 0;
    for (int l = 1; l <= 6; l++) begin
      if (bus.resp_valid) begin
        seen = l;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_req(input bit wr, input bit [1:0] size, input bit sgn,
                        input bit [31:0] a, input bit [31:0] wd, input string tag);
    bit e;
    bit [31:0] rd, nw;
    int lat, nwr, wr0, seen;
    model(wr, size, sgn, a, wd, e, rd, lat, nwr, nw);
    @(negedge clk);
    bus.req_wr = wr; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
    for (int i = 0; i < 10 && !bus.req_ready; i++) @(negedge clk);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    wr0 = wr_cnt;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_wr = 1'($urandom); bus.req_size = 2'($urandom); bus.req_signed = 1'($urandom);
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    wait_resp(seen);
    check({tag, "_lat"}, 32'(seen), 32'(lat));
    check({tag, "_err"}, 32'(bus.resp_err), 32'(e));
    check({tag, "_rdata"}, bus.resp_rdata, rd);
    check({tag, "_nwr"}, 32'(wr_cnt - wr0), 32'(nwr));
    if (nwr != 0) begin
      check({tag, "_waddr"}, last_wa, {a[31:2], 2'b00});
      check({tag, "_wdata"}, last_wd, nw);
      ref_mem[a[9:2]] = nw;
    end
    check({tag, "_memword"}, mem[a[9:2]], ref_mem[a[9:2]]);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit e;
    bit [31:0] rd_a, rd_b, nw;
    int lat, nwr, seen, wr0, r0, a0;

    rst_n = 1'b0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 256; i++) poke(i, $urandom);

    // Reset state
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);

    // Directed cases
    poke(32'h10 >> 2, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "wload");
    do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, "sbyte");
    do_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, "ubyte");
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, "shalf");
    do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, "wload_sgn");
    poke(32'h20 >> 2, 32'h11223344);
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h5555AAAA, "hstore");
    check("hstore_word", mem[32'h20 >> 2], 32'hAAAA3344);
    do_req(1'b1, 2'b00, 1'b0, 32'h23, 32'hFFFFFF77, "bstore");
    do_req(1'b1, 2'b10, 1'b0, 32'h24, 32'h01020304, "wstore");
    do_req(1'b0, 2'b10, 1'b0, 32'h21, 32'h0, "misalign_w");
    do_req(1'b0, 2'b01, 1'b0, 32'h23, 32'h0, "misalign_h");
    do_req(1'b1, 2'b11, 1'b0, 32'h20, 32'h0, "illegal");

    // Reset while the sub-word store sits in its write cycle
    poke(12, 32'hCAFEF00D);
    wr0 = wr_cnt;
    r0  = resp_cnt;
    @(negedge clk);
    bus.req_wr = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
    bus.req_addr = 32'h31; bus.req_wdata = 32'h55; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rstw_in_write", 32'(bus.mem_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_wr_gated", 32'(bus.mem_wr), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rstw_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rstw_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("rstw_no_resp", 32'(resp_cnt - r0), 32'd0);
    check("rstw_mem", mem[12], 32'hCAFEF00D);

    // Back-to-back with req_valid held high and req_* changing while busy
    poke(16, $urandom);
    model(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, e, rd_a, lat, nwr, nw);
    model(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, e, rd_b, lat, nwr, nw);
    @(negedge clk);
    a0 = acc_cnt;
    bus.req_wr = 1'b0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
    bus.req_addr = 32'h40; bus.req_wdata = 32'h0; bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_size = 2'b01; bus.req_signed = 1'b1; bus.req_addr = 32'h42;
    wait_resp(seen);
    check("b2b_a_lat", 32'(seen), 32'd2);
    check("b2b_a_rdata", bus.resp_rdata, rd_a);
    check("b2b_a_busy", 32'(bus.req_ready), 32'd0);
    check("b2b_one_acc", 32'(acc_cnt - a0), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_not_yet", 32'(acc_cnt - a0), 32'd1);
    check("b2b_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("b2b_two_acc", 32'(acc_cnt - a0), 32'd2);
    wait_resp(seen);
    check("b2b_b_lat", 32'(seen), 32'd2);
    check("b2b_b_rdata", bus.resp_rdata, rd_b);

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             32'($urandom_range(0, 1023)), $urandom, "rand");
    end

    check("wdata_zero_idle", 32'(wdata_viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
